// File: rtl/v_vram_resp.sv
// VRAM responder: serves vector-core read/write requests from on-chip memory after a reset-time clear sweep.
// Optional macro VRAM_RD_PIPE_EN adds an output register stage (read latency 2 instead of 1).
module v_vram_resp #(
    parameter int unsigned VRAM_AW    = 64,
    parameter int unsigned VRAM_DW    = 512,
    parameter int unsigned VRAM_DEPTH = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vram_r_ena,
    input  logic [VRAM_AW-1:0] vram_r_addr,
    output logic [VRAM_DW-1:0] vram_r_data,
    output logic               vram_r_valid,
    input  logic               vram_w_ena,
    input  logic [VRAM_AW-1:0] vram_w_addr,
    input  logic [VRAM_DW-1:0] vram_w_data,
    input  logic [VRAM_DW-1:0] vram_w_mask,
    output logic               vram_busy,
    output logic               vram_err
);

    localparam int unsigned OFF = $clog2(VRAM_DW / 8);
    localparam int unsigned IDX = $clog2(VRAM_DEPTH);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX-1:0]     cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [VRAM_DW-1:0] rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               err_q, err_d;

    logic [VRAM_DW-1:0] mem_q [VRAM_DEPTH];
    logic               mem_we_c;
    logic [IDX-1:0]     mem_waddr_c;
    logic [VRAM_DW-1:0] mem_wdata_c;

    logic               run_c;
    logic [IDX-1:0]     r_idx_c, w_idx_c;
    logic               r_oor_c, w_oor_c;
    logic               r_req_c, w_req_c;
    logic [VRAM_DW-1:0] rd_line_c, w_line_c, w_merge_c;
    logic               unused_addr_lsbs;

    // Address decode: byte offset bits are ignored, anything above the line index is out of range.
    always_comb begin
        run_c     = (state_q == S_RUN);
        r_idx_c   = vram_r_addr[OFF +: IDX];
        w_idx_c   = vram_w_addr[OFF +: IDX];
        r_oor_c   = |vram_r_addr[VRAM_AW-1:OFF+IDX];
        w_oor_c   = |vram_w_addr[VRAM_AW-1:OFF+IDX];
        r_req_c   = run_c & vram_r_ena;
        w_req_c   = run_c & vram_w_ena & ~w_oor_c;
        rd_line_c = mem_q[r_idx_c];
        w_line_c  = mem_q[w_idx_c];
        w_merge_c = (w_line_c & ~vram_w_mask) | (vram_w_data & vram_w_mask);
    end

    assign unused_addr_lsbs = ^{vram_r_addr[OFF-1:0], vram_w_addr[OFF-1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_INIT;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_INIT && cnt_q == IDX'(VRAM_DEPTH - 1)) state_d = S_RUN;
    end

    always_comb begin
        cnt_d       = cnt_q;
        busy_d      = (state_d == S_INIT);
        rd_valid_d  = r_req_c;
        rd_data_d   = rd_data_q;
        err_d       = run_c & ((vram_r_ena & r_oor_c) | (vram_w_ena & w_oor_c));
        mem_we_c    = 1'b0;
        mem_waddr_c = w_idx_c;
        mem_wdata_c = w_merge_c;
        if (state_q == S_INIT) begin
            cnt_d       = cnt_q + IDX'(1);
            mem_we_c    = 1'b1;
            mem_waddr_c = cnt_q;
            mem_wdata_c = '0;
        end else begin
            mem_we_c = w_req_c;
        end
        // Write-first: a same-line write in the same cycle is visible to the read.
        if (r_req_c) begin
            if (r_oor_c)                            rd_data_d = '0;
            else if (w_req_c && w_idx_c == r_idx_c) rd_data_d = w_merge_c;
            else                                    rd_data_d = rd_line_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) mem_q[mem_waddr_c] <= mem_wdata_c;
    end

    assign vram_busy = busy_q;

`ifdef VRAM_RD_PIPE_EN
    logic [VRAM_DW-1:0] p_data_q, p_data_d;
    logic               p_valid_q, p_err_q;

    always_comb begin
        p_data_d = p_data_q;
        if (rd_valid_q) p_data_d = rd_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_data_q  <= '0;
            p_valid_q <= 1'b0;
            p_err_q   <= 1'b0;
        end else begin
            p_data_q  <= p_data_d;
            p_valid_q <= rd_valid_q;
            p_err_q   <= err_q;
        end
    end

    assign vram_r_data  = p_data_q;
    assign vram_r_valid = p_valid_q;
    assign vram_err     = p_err_q;
`else
    assign vram_r_data  = rd_data_q;
    assign vram_r_valid = rd_valid_q;
    assign vram_err     = err_q;
`endif

endmodule

// File: tb/tb_v_vram_resp.sv
// Scoreboard bench for v_vram_resp: directed requests push expectations, a negedge monitor checks responses.
module tb_v_vram_resp;

`ifdef VRAM_RD_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         vram_r_ena = 1'b0;
    logic [63:0]  vram_r_addr = '0;
    logic [511:0] vram_r_data;
    logic         vram_r_valid;
    logic         vram_w_ena = 1'b0;
    logic [63:0]  vram_w_addr = '0;
    logic [511:0] vram_w_data = '0;
    logic [511:0] vram_w_mask = '0;
    logic         vram_busy;
    logic         vram_err;

    typedef struct {
        logic [511:0] data;
        int           cyc;
    } exp_t;

    exp_t         rq[$];
    int           eq[$];
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [511:0] last_exp = '0;

    localparam logic [511:0] A5    = {64{8'hA5}};
    localparam logic [511:0] ONES  = '1;
    localparam logic [511:0] ZERO  = '0;
    localparam logic [511:0] LOW32 = 512'hFFFF_FFFF;

    v_vram_resp dut (
        .clk          (clk),
        .rst          (rst),
        .vram_r_ena   (vram_r_ena),
        .vram_r_addr  (vram_r_addr),
        .vram_r_data  (vram_r_data),
        .vram_r_valid (vram_r_valid),
        .vram_w_ena   (vram_w_ena),
        .vram_w_addr  (vram_w_addr),
        .vram_w_data  (vram_w_data),
        .vram_w_mask  (vram_w_mask),
        .vram_busy    (vram_busy),
        .vram_err     (vram_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic re, input logic [63:0] ra, input logic we, input logic [63:0] wa,
                         input logic [511:0] wd, input logic [511:0] wm,
                         input logic [511:0] exp_d, input logic exp_e);
        exp_t e;
        @(negedge clk);
        vram_r_ena  = re;
        vram_r_addr = ra;
        vram_w_ena  = we;
        vram_w_addr = wa;
        vram_w_data = wd;
        vram_w_mask = wm;
        if (re) begin
            e.data = exp_d;
            e.cyc  = cyc + LAT;
            rq.push_back(e);
            last_exp = exp_d;
        end
        if (exp_e) eq.push_back(cyc + LAT);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vram_r_ena = 1'b0;
            vram_w_ena = 1'b0;
        end
    endtask

    // Counts cycles busy stays high after release; optionally drops a read into the first init cycle.
    task automatic busy_window(input string name, input logic rd_in_init);
        int n;
        n = 0;
        if (rd_in_init) begin
            vram_r_ena  = 1'b1;
            vram_r_addr = 64'h40;
        end
        rst = 1'b1;
        while (n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            vram_r_ena = 1'b0;
            if (!vram_busy) break;
        end
        n_cmp++;
        if (n != 1024) begin
            n_bad++;
            $display("FAIL %s: busy cycles got %0d want 1024", name, n);
        end
    endtask

    // Response monitor: every valid must match the oldest pending read at its due cycle.
    always @(negedge clk) begin
        if (rst) begin
            logic exp_err;
            if (vram_r_valid) begin
                n_cmp++;
                if (rq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_valid: got valid=1 data=%h want no response", vram_r_data);
                end else begin
                    exp_t e;
                    e = rq.pop_front();
                    if (e.cyc != cyc || vram_r_data !== e.data) begin
                        n_bad++;
                        $display("FAIL read_resp: got cyc %0d data %h want cyc %0d data %h",
                                 cyc, vram_r_data, e.cyc, e.data);
                    end
                end
            end
            exp_err = (eq.size() > 0 && eq[0] == cyc);
            if (exp_err) void'(eq.pop_front());
            if (exp_err || vram_err) begin
                n_cmp++;
                if (vram_err !== exp_err) begin
                    n_bad++;
                    $display("FAIL err_pulse: got %b want %b at cyc %0d", vram_err, exp_err, cyc);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check1("rst_valid", vram_r_valid, 1'b0);
        check1("rst_err", vram_err, 1'b0);
        check1("rst_busy", vram_busy, 1'b1);
        check_data("rst_data", vram_r_data, ZERO);

        busy_window("init_sweep", 1'b0);

        drive(1, 64'h40, 0, 0, ZERO, ZERO, ZERO, 0);
        drive(0, 0, 1, 64'h80, A5, ONES, ZERO, 0);
        drive(1, 64'h80, 0, 0, ZERO, ZERO, A5, 0);
        drive(1, 64'hBF, 0, 0, ZERO, ZERO, A5, 0);
        drive(0, 0, 1, 64'hC0, ONES, LOW32, ZERO, 0);
        drive(1, 64'hC0, 0, 0, ZERO, ZERO, LOW32, 0);
        drive(1, 64'hC0, 1, 64'hC0, 512'h1234, ONES, 512'h1234, 0);
        drive(1, 64'hC0, 1, 64'hC0, ONES, 512'hFF00, 512'hFF34, 0);
        drive(1, 64'h1_0000, 1, 64'h2_0040, ONES, ONES, ZERO, 1);
        drive(1, 64'h40, 0, 0, ZERO, ZERO, ZERO, 0);
        drive(1, 64'h80, 1, 64'h100, 512'hDEAD, ONES, A5, 0);
        drive(1, 64'h100, 0, 0, ZERO, ZERO, 512'hDEAD, 0);
        drive(0, 0, 1, 64'h80, ZERO, ZERO, ZERO, 0);
        drive(0, 0, 1, 64'h1_0080, ONES, ONES, ZERO, 1);
        drive(1, 64'h80, 0, 0, ZERO, ZERO, A5, 0);
        drive(1, 64'hC0, 0, 0, ZERO, ZERO, 512'hFF34, 0);
        drive(1, 64'h100, 0, 0, ZERO, ZERO, 512'hDEAD, 0);
        drive(1, 64'h4_0000, 0, 0, ZERO, ZERO, ZERO, 1);
        drive(1, 64'hFFC0, 0, 0, ZERO, ZERO, ZERO, 0);
        idle(5);

        check_data("data_hold", vram_r_data, last_exp);
        check1("run_busy", vram_busy, 1'b0);
        n_cmp++;
        if (rq.size() != 0 || eq.size() != 0) begin
            n_bad++;
            $display("FAIL pending: got %0d reads %0d errs outstanding want 0", rq.size(), eq.size());
        end

        // Make the output nonzero, then check that reset clears it without a clock edge.
        drive(1, 64'h80, 0, 0, ZERO, ZERO, A5, 0);
        idle(LAT + 1);
        #3;
        rst = 1'b0;
        #1;
        check_data("async_rst_data", vram_r_data, ZERO);
        check1("async_rst_busy", vram_busy, 1'b1);

        @(negedge clk);
        rst = 1'b1;
        repeat (500) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check1("mid_sweep_busy", vram_busy, 1'b1);
        check1("mid_sweep_valid", vram_r_valid, 1'b0);
        @(negedge clk);
        busy_window("restart_sweep", 1'b1);

        drive(1, 64'h80, 0, 0, ZERO, ZERO, ZERO, 0);
        drive(1, 64'hC0, 0, 0, ZERO, ZERO, ZERO, 0);
        idle(5);
        n_cmp++;
        if (rq.size() != 0 || eq.size() != 0) begin
            n_bad++;
            $display("FAIL pending_end: got %0d reads %0d errs outstanding want 0", rq.size(), eq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/v_vram_resp.md
Name: v_vram_resp

Overview:
- Responder end of the vector-core VRAM interface: accepts the core's read and write requests (`vram_r_*` / `vram_w_*`) and serves them from on-chip vector memory.
- Read latency is fixed; writes are merged under a bit-granular mask.
- After every reset the memory is hardware-cleared before requests are accepted.
- Sits beside the vector core top in the vector subsystem, in place of a behavioural memory model.

Parameters:
- VRAM_AW, 64, byte-address width of `vram_r_addr` / `vram_w_addr`.
- VRAM_DW, 512, data and mask width (one vector register line).
- VRAM_DEPTH, 1024, number of VRAM_DW-wide lines; power of two.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- vram_r_ena  input  1  read request, sampled each cycle.
- vram_r_addr  input  VRAM_AW  read byte address.
- vram_r_data  output  VRAM_DW  read data.
- vram_r_valid  output  1  `vram_r_data` valid this cycle.
- vram_w_ena  input  1  write request, sampled each cycle.
- vram_w_addr  input  VRAM_AW  write byte address.
- vram_w_data  input  VRAM_DW  write data.
- vram_w_mask  input  VRAM_DW  per-bit write enable; 1 = update bit.
- vram_busy  output  1  init sweep in progress; requests ignored.
- vram_err  output  1  one-cycle pulse: out-of-range access.

Behaviour:
- Address decode:
  - OFF = log2(VRAM_DW/8) = 6; IDX = log2(VRAM_DEPTH) = 10.
  - Line index = addr[OFF+IDX-1:OFF], i.e. addr[15:6].
  - addr[OFF-1:0] ignored (line-aligned access).
  - addr[VRAM_AW-1:OFF+IDX] nonzero = out of range.
- Reset: while `rst` = 0, `vram_r_data`=0, `vram_r_valid`=0, `vram_err`=0, `vram_busy`=1. Memory contents undefined.
- FSM states INIT and RUN. Reset enters INIT with sweep counter = 0.
- INIT:
  - Each cycle writes line[cnt] = 0, cnt++.
  - After line VRAM_DEPTH-1 is written, go to RUN.
  - `vram_busy`=1 for exactly VRAM_DEPTH cycles after `rst` deasserts.
  - Requests in INIT are dropped: no `vram_r_valid`, no `vram_err`, no memory update.
- RUN: `vram_busy`=0; never leaves RUN except via reset.
- Reset asserted mid-sweep or mid-request: outputs clear immediately (async); sweep restarts from line 0.
- Read (RUN):
  - `vram_r_ena`=1 in cycle N gives `vram_r_valid`=1 and data in cycle N+1 (latency 1).
  - `vram_r_valid`=0 when no read was issued; `vram_r_data` holds its last value.
  - Back-to-back reads supported every cycle.
- Write (RUN): `vram_w_ena`=1 gives line <= (line & ~mask) | (data & mask) at the edge. Mask all-zero = no change.
- Simultaneous read and write, same line: read returns the merged post-write value (write-first bypass).
- Simultaneous read and write, different lines: both serviced independently.
- Out-of-range:
  - Read: `vram_r_valid`=1 with `vram_r_data`=0 at N+1.
  - Write: dropped.
  - `vram_err`=1 for one cycle at N+1 (either or both requests).
- No backpressure: the responder accepts every request in RUN.

Optional Feature:
- Macro: VRAM_RD_PIPE_EN.
- Defined:
  - Extra output register stage; read latency is 2 (valid at N+2).
  - `vram_err` is also delayed to N+2.
  - Write-first bypass still applies, using memory state at request cycle N.
  - Back-to-back throughput is unchanged.
- Undefined: latency 1 as above.

Test Plan:
- Release reset, hold `vram_r_ena`=0 -> `vram_busy`=1 for exactly 1024 cycles then 0; read addr 0x40 -> `vram_r_valid` next cycle, data all-zero.
- Write addr 0x80, data {64{8'hA5}}, mask all-ones; read 0x80 next cycle -> data {64{8'hA5}}; read 0xBF (same line) -> same data.
- Write addr 0xC0, data all-ones, mask = 512'h0...0_FFFF_FFFF; read -> 512'h0...0_FFFF_FFFF, upper 480 bits 0.
- Same cycle: write line 3 (addr 0xC0) data 512'h1234, full mask, and read 0xC0 -> `vram_r_data`=512'h1234 at N+1.
- Read addr 0x1_0000 and write addr 0x2_0040 -> `vram_r_valid`=1, data 0, `vram_err` pulses 1 cycle; line 1 unchanged on later read.
- Assert `rst`=0 at sweep count 500, release -> `vram_busy` stays 1 for a full 1024 cycles; a read issued during that window gets no `vram_r_valid`.
